// File: rtl/mmio_timer_pkg.sv
// Shared types and constants for the memory-mapped machine timer.
// Offsets are byte offsets from the peripheral base address.
package mmio_timer_pkg;

   // Data-memory access size as issued by the core's load/store path.
   typedef enum logic [1:0] {
      DmemByte = 2'b00,
      DmemHalf = 2'b01,
      DmemWord = 2'b10
   } op_enum_dmem_size;

   localparam logic [4:0] MTIMER_OFF_MTIME_LO    = 5'h00;
   localparam logic [4:0] MTIMER_OFF_MTIME_HI    = 5'h04;
   localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] MTIMER_OFF_CTRL        = 5'h10;
   localparam logic [4:0] MTIMER_OFF_STATUS      = 5'h14;

   localparam int unsigned MTIMER_CTRL_EN       = 0;
   localparam int unsigned MTIMER_CTRL_IRQ_EN   = 1;
   localparam int unsigned MTIMER_CTRL_PRE_LSB  = 8;
   localparam int unsigned MTIMER_CTRL_PRE_MSB  = 15;

   localparam int unsigned MTIMER_STATUS_HIT    = 0;
   localparam int unsigned MTIMER_STATUS_MATCH  = 1;
   localparam int unsigned MTIMER_STATUS_ERR    = 2;

endpackage

// File: rtl/mmio_timer_lane.sv
// Byte/half/word lane helper for 32-bit MMIO registers: merges a store into
// the addressed lane and extracts/extends a load. Purely combinational.
module mmio_lane
   import mmio_timer_pkg::*;
(
   input  logic [31:0]      reg_i,      // current register value
   input  logic [31:0]      wdata_i,    // right-aligned store data
   input  logic [1:0]       off_i,      // addr[1:0]
   input  op_enum_dmem_size size_i,
   input  logic             zero_ex_i,
   output logic [31:0]      merged_o,   // register value after the store
   output logic [31:0]      wmask_o,    // bits touched by the store
   output logic [31:0]      wshift_o,   // store data placed in its lane
   output logic [31:0]      rdata_o,    // extended load data
   output logic             aligned_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = reg_i[{off_i, 3'b000} +: 8];
   assign rd_half = reg_i[{off_i[1], 4'b0000} +: 16];

   // Lane mask, placed store data and load extraction per access size.
   always_comb begin
      wmask_o   = 32'h0;
      wshift_o  = wdata_i;
      rdata_o   = 32'h0;
      aligned_o = 1'b0;
      case (size_i)
         DmemByte: begin
            aligned_o = 1'b1;
            wmask_o   = 32'h0000_00FF << {off_i, 3'b000};
            wshift_o  = {4{wdata_i[7:0]}};
            rdata_o   = zero_ex_i ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         end
         DmemHalf: begin
            aligned_o = ~off_i[0];
            wmask_o   = off_i[0] ? 32'h0 : (32'h0000_FFFF << {off_i[1], 4'b0000});
            wshift_o  = {2{wdata_i[15:0]}};
            if (!off_i[0]) begin
               rdata_o = zero_ex_i ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
         end
         DmemWord: begin
            aligned_o = (off_i == 2'b00);
            wmask_o   = aligned_o ? 32'hFFFF_FFFF : 32'h0;
            rdata_o   = aligned_o ? reg_i : 32'h0;
         end
         default: ;
      endcase
   end

   assign merged_o = (reg_i & ~wmask_o) | (wshift_o & wmask_o);

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// registered compare and level interrupt. Reads are combinational, writes land
// on the clock edge. Define MMIO_TIMER_ERR_EN to add the bus_err output and the
// sticky STATUS.ERR flag for misaligned or unmapped accesses.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
   input  logic             clk,
   input  logic             res,
   input  logic             req,
   input  logic             ren,
   input  logic             wen,
   input  logic [31:0]      addr,
   input  op_enum_dmem_size mem_size,
   input  logic             zero_ex,
   input  logic [XLEN-1:0]  wr_data,
   output logic [XLEN-1:0]  rd_data,
   output logic             irq
`ifdef MMIO_TIMER_ERR_EN
   ,
   output logic             bus_err
`endif
);

   logic        hit;
   logic [2:0]  widx;
   logic [31:0] rd_word, merged, wmask, wshift, rd_lane;
   logic        aligned, we;
   logic        we_mlo, we_mhi, we_clo, we_chi, we_ctrl, we_stat;
   logic        tick, err_bit;

   logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic        en_q, en_d, irq_en_q, irq_en_d;
   logic [7:0]  pre_q, pre_d, pcnt_q, pcnt_d;
   logic        hit_q, hit_d, match_q, match_d;

   assign hit  = (addr[31:5] == BASE_ADDR[31:5]) & req;
   assign widx = addr[4:2];

   // Register read mux; word slots 6 and 7 read as zero.
   always_comb begin
      rd_word = 32'h0;
      case (widx)
         MTIMER_OFF_MTIME_LO[4:2]:    rd_word = mtime_q[31:0];
         MTIMER_OFF_MTIME_HI[4:2]:    rd_word = mtime_q[63:32];
         MTIMER_OFF_MTIMECMP_LO[4:2]: rd_word = mtimecmp_q[31:0];
         MTIMER_OFF_MTIMECMP_HI[4:2]: rd_word = mtimecmp_q[63:32];
         MTIMER_OFF_CTRL[4:2]:        rd_word = {16'h0, pre_q, 6'h0, irq_en_q, en_q};
         MTIMER_OFF_STATUS[4:2]:      rd_word = {29'h0, err_bit, match_q, hit_q};
         default:                     rd_word = 32'h0;
      endcase
   end

   mmio_lane u_lane (
      .reg_i     (rd_word),
      .wdata_i   (wr_data),
      .off_i     (addr[1:0]),
      .size_i    (mem_size),
      .zero_ex_i (zero_ex),
      .merged_o  (merged),
      .wmask_o   (wmask),
      .wshift_o  (wshift),
      .rdata_o   (rd_lane),
      .aligned_o (aligned)
   );

   assign rd_data = (hit & ren & aligned) ? rd_lane : '0;

   assign we      = hit & wen & aligned;
   assign we_mlo  = we & (widx == MTIMER_OFF_MTIME_LO[4:2]);
   assign we_mhi  = we & (widx == MTIMER_OFF_MTIME_HI[4:2]);
   assign we_clo  = we & (widx == MTIMER_OFF_MTIMECMP_LO[4:2]);
   assign we_chi  = we & (widx == MTIMER_OFF_MTIMECMP_HI[4:2]);
   assign we_ctrl = we & (widx == MTIMER_OFF_CTRL[4:2]);
   assign we_stat = we & (widx == MTIMER_OFF_STATUS[4:2]);

   assign tick = en_q & (pcnt_q == pre_q);
   assign irq  = hit_q & irq_en_q;

   // Next-state for counter, compare, control and status.
   always_comb begin
      pcnt_d = pcnt_q;
      if (en_q) begin
         pcnt_d = tick ? 8'h0 : pcnt_q + 8'h1;
      end
      if (we_ctrl) begin
         pcnt_d = 8'h0;
      end

      // A software write owns its half; the other half keeps the increment.
      mtime_d = tick ? mtime_q + 64'h1 : mtime_q;
      if (we_mlo) mtime_d[31:0]  = merged;
      if (we_mhi) mtime_d[63:32] = merged;

      mtimecmp_d = mtimecmp_q;
      if (we_clo) mtimecmp_d[31:0]  = merged;
      if (we_chi) mtimecmp_d[63:32] = merged;

      en_d     = en_q;
      irq_en_d = irq_en_q;
      pre_d    = pre_q;
      if (we_ctrl) begin
         en_d     = merged[MTIMER_CTRL_EN];
         irq_en_d = merged[MTIMER_CTRL_IRQ_EN];
         pre_d    = merged[MTIMER_CTRL_PRE_MSB:MTIMER_CTRL_PRE_LSB];
      end

      hit_d = (mtime_q >= mtimecmp_q);

      // Set on the rising edge of hit_q beats a same-cycle clear.
      match_d = match_q;
      if (we_stat & wmask[MTIMER_STATUS_MATCH] & wshift[MTIMER_STATUS_MATCH]) begin
         match_d = 1'b0;
      end
      if (hit_d & ~hit_q) begin
         match_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (res) begin
         mtime_q    <= 64'h0;
         mtimecmp_q <= '1;
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         pre_q      <= 8'h0;
         pcnt_q     <= 8'h0;
         hit_q      <= 1'b0;
         match_q    <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         pre_q      <= pre_d;
         pcnt_q     <= pcnt_d;
         hit_q      <= hit_d;
         match_q    <= match_d;
      end
   end

`ifdef MMIO_TIMER_ERR_EN
   logic err_q, err_d;

   assign bus_err = hit & (ren | wen) & (~aligned | (widx[2] & widx[1]));
   assign err_bit = err_q;

   // Sticky error flag; a new error in the clearing cycle keeps it set.
   always_comb begin
      err_d = err_q;
      if (we_stat & wmask[MTIMER_STATUS_ERR] & wshift[MTIMER_STATUS_ERR]) begin
         err_d = 1'b0;
      end
      if (bus_err) begin
         err_d = 1'b1;
      end
   end

   // Error flag register.
   always_ff @(posedge clk) begin
      if (res) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign err_bit = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: the driver queues expected values as it
// issues accesses, a negedge monitor pops and compares them.
module tb_mmio_timer;
   import mmio_timer_pkg::*;

   localparam logic [31:0] Base = 32'h0000_1000;

   logic             clk = 1'b0;
   logic             res;
   logic             req, ren, wen, zero_ex;
   logic [31:0]      addr, wr_data, rd_data;
   op_enum_dmem_size mem_size;
   logic             irq;
`ifdef MMIO_TIMER_ERR_EN
   logic             bus_err;
   localparam logic [31:0] StErr = 32'h4;
`else
   localparam logic [31:0] StErr = 32'h0;
`endif

   always #5 clk = ~clk;

   mmio_timer #(
      .XLEN      (32),
      .BASE_ADDR (Base)
   ) dut (
      .clk      (clk),
      .res      (res),
      .req      (req),
      .ren      (ren),
      .wen      (wen),
      .addr     (addr),
      .mem_size (mem_size),
      .zero_ex  (zero_ex),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .irq      (irq)
`ifdef MMIO_TIMER_ERR_EN
      ,
      .bus_err  (bus_err)
`endif
   );

   typedef struct {
      string       name;
      int          kind;   // 0 rd_data, 1 irq, 2 bus_err
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic chk      = 1'b0;

   // Monitor: whenever the driver presents a checked cycle, pop and compare.
   always @(negedge clk) begin
      if (chk) begin
         exp_t        e;
         logic [31:0] act;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL monitor: output presented with empty scoreboard at %0t", $time);
         end else begin
            e = sb.pop_front();
            case (e.kind)
               0:       act = rd_data;
               1:       act = {31'h0, irq};
`ifdef MMIO_TIMER_ERR_EN
               default: act = {31'h0, bus_err};
`else
               default: act = 32'h0;
`endif
            endcase
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic bus_idle();
      req = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'h0;
      wr_data = 32'h0; mem_size = DmemWord; zero_ex = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] data,
                     input op_enum_dmem_size sz = DmemWord);
      req = 1'b1; wen = 1'b1; addr = Base + off; wr_data = data; mem_size = sz;
      @(posedge clk);
      #1;
      bus_idle();
   endtask

   task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp,
                     input op_enum_dmem_size sz = DmemWord, input logic zex = 1'b1);
      req = 1'b1; ren = 1'b1; addr = Base + off; mem_size = sz; zero_ex = zex;
      sb.push_back('{name, 0, exp});
      chk = 1'b1;
      @(posedge clk);
      #1;
      chk = 1'b0;
      bus_idle();
   endtask

   task automatic chk_irq(input string name, input logic exp);
      sb.push_back('{name, 1, {31'h0, exp}});
      chk = 1'b1;
      @(posedge clk);
      #1;
      chk = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus_idle();
      res = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      res = 1'b0;

      // Reset values
      rd("rst_mtime_lo", 32'h00, 32'h0000_0000);
      rd("rst_mtime_hi", 32'h04, 32'h0000_0000);
      rd("rst_cmp_lo",   32'h08, 32'hFFFF_FFFF);
      rd("rst_cmp_hi",   32'h0C, 32'hFFFF_FFFF);
      rd("rst_ctrl",     32'h10, 32'h0000_0000);
      rd("rst_status",   32'h14, 32'h0000_0000);
      rd("rsvd_18",      32'h18, 32'h0000_0000);
      rd("rsvd_1c",      32'h1C, 32'h0000_0000);
      chk_irq("rst_irq", 1'b0);
      wr(32'h14, 32'h4);   // drop any ERR left by the reserved reads

      // Prescale 3: one increment every 4 cycles
      wr(32'h10, 32'hABCD_03FD);
      rd("ctrl_readback", 32'h10, 32'h0000_0301);
      idle(38);
      rd("presc_39cyc", 32'h00, 32'd9);
      rd("presc_40cyc", 32'h00, 32'd10);
      wr(32'h10, 32'h0);
      idle(3);
      rd("presc_hold", 32'h00, 32'd10);

      // 64-bit carry
      wr(32'h00, 32'hFFFF_FFFE);
      wr(32'h04, 32'h0);
      wr(32'h10, 32'h1);
      rd("carry_lo_t0", 32'h00, 32'hFFFF_FFFE);
      rd("carry_hi_t1", 32'h04, 32'h0);
      rd("carry_lo_t2", 32'h00, 32'h0);
      rd("carry_hi_t3", 32'h04, 32'h1);
      wr(32'h10, 32'h0);

      // LO write on the carry tick: write wins for LO, HI still carries
      wr(32'h00, 32'hFFFF_FFFF);
      wr(32'h04, 32'h0);
      wr(32'h10, 32'h1);
      wr(32'h00, 32'h1234_5678);
      rd("wrcarry_lo", 32'h00, 32'h1234_5678);
      rd("wrcarry_hi", 32'h04, 32'h1);
      wr(32'h10, 32'h0);

      // Compare and interrupt
      wr(32'h00, 32'h0);
      wr(32'h04, 32'h0);
      wr(32'h08, 32'h5);
      wr(32'h0C, 32'h0);
      wr(32'h10, 32'h3);
      idle(4);
      chk_irq("irq_mtime4", 1'b0);
      chk_irq("irq_mtime5", 1'b0);
      chk_irq("irq_rise",   1'b1);
      rd("status_match", 32'h14, 32'h3);
      wr(32'h14, 32'h2);
      rd("status_w1c", 32'h14, 32'h1);
      chk_irq("irq_after_w1c", 1'b1);
      wr(32'h0C, 32'h1);
      chk_irq("irq_lag", 1'b1);
      chk_irq("irq_clear", 1'b0);
      wr(32'h10, 32'h0);

      // Byte/half lanes and extension
      wr(32'h08, 32'hFFFF_FFFF);
      wr(32'h09, 32'h0000_0080, DmemByte);
      rd("sb_merge",  32'h08, 32'hFFFF_80FF);
      rd("lb_sext",   32'h09, 32'hFFFF_FF80, DmemByte, 1'b0);
      rd("lb_zext",   32'h09, 32'h0000_0080, DmemByte, 1'b1);
      rd("lh_zext",   32'h08, 32'h0000_80FF, DmemHalf, 1'b1);
      wr(32'h0A, 32'h0000_1234, DmemHalf);
      rd("sh_merge",  32'h08, 32'h1234_80FF);

      // Misaligned half store/load
      wr(32'h00, 32'hA5A5_0000);
      wr(32'h04, 32'h0);
      wr(32'h01, 32'h0000_FFFF, DmemHalf);
      rd("misal_noeffect", 32'h00, 32'hA5A5_0000);
      rd("misal_lh", 32'h01, 32'h0, DmemHalf, 1'b0);
      rd("status_err", 32'h14, StErr);
`ifdef MMIO_TIMER_ERR_EN
      req = 1'b1; ren = 1'b1; addr = Base + 32'h1; mem_size = DmemHalf;
      sb.push_back('{"bus_err_misal", 2, 32'h1});
      chk = 1'b1;
      @(posedge clk);
      #1;
      chk = 1'b0;
      bus_idle();
`endif

      // Reset mid-count beats a same-cycle write
      wr(32'h10, 32'h1);
      idle(3);
      req = 1'b1; wen = 1'b1; addr = Base; wr_data = 32'h55; res = 1'b1;
      @(posedge clk);
      #1;
      bus_idle();
      res = 1'b0;
      rd("rst2_mtime_lo", 32'h00, 32'h0);
      rd("rst2_ctrl",     32'h10, 32'h0);
      rd("rst2_cmp_lo",   32'h08, 32'hFFFF_FFFF);

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
